// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core.
// Sequences hazard stalls, memory-busy freezes, the multicycle divider window
// and exception redirects. It also generates the MEM->ID forwarding selects
// used by branch source selection.
module pipe_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs_regf,
  input  logic [4:0] id_rt_regf,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic [4:0] ex_rd_regf,
  input  logic       ex_wr,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd_regf,
  input  logic       mem_wr,
  input  logic       mem_is_load,
  input  logic       ex_div_start,
  input  logic       imem_busy,
  input  logic       dmem_busy,
  input  logic       exc_valid,
  output logic       forward_rs,
  output logic       forward_rt,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       flush_wb,
  output logic       div_busy,
  output logic       exc_redirect
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    DIV = 2'd1,
    EXC = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic hz, exc, mem_busy;

  // Source-register matches against EX and MEM destinations; $0 never matches
  assign rs_hit_ex  = id_uses_rs & (id_rs_regf != 5'd0) & ex_wr  & (ex_rd_regf  == id_rs_regf);
  assign rt_hit_ex  = id_uses_rt & (id_rt_regf != 5'd0) & ex_wr  & (ex_rd_regf  == id_rt_regf);
  assign rs_hit_mem = id_uses_rs & (id_rs_regf != 5'd0) & mem_wr & (mem_rd_regf == id_rs_regf);
  assign rt_hit_mem = id_uses_rt & (id_rt_regf != 5'd0) & mem_wr & (mem_rd_regf == id_rt_regf);

  // Load-use, or a branch that needs a result not yet available to ID
  assign hz = ((rs_hit_ex | rt_hit_ex) & (ex_is_load | id_is_branch))
            | (id_is_branch & (rs_hit_mem | rt_hit_mem) & mem_is_load);

  assign exc      = exc_valid | (state == EXC);
  assign mem_busy = imem_busy | dmem_busy;

  // State and divider counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and control outputs; priority is exception > memory busy > divider > hazard
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    forward_rs   = 1'b0;
    forward_rt   = 1'b0;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    stall_mem    = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    flush_mem    = 1'b0;
    flush_wb     = 1'b0;
    div_busy     = 1'b0;
    exc_redirect = 1'b0;

    if (!rst) begin
      forward_rs = rs_hit_mem & ~mem_is_load;
      forward_rt = rt_hit_mem & ~mem_is_load;
      div_busy   = (state == DIV);

      if (exc) begin
        // Flush everything; redirect only once instruction fetch can accept it
        flush_id     = 1'b1;
        flush_ex     = 1'b1;
        flush_mem    = 1'b1;
        flush_wb     = 1'b1;
        cnt_nxt      = '0;
        exc_redirect = ~imem_busy;
        state_nxt    = imem_busy ? EXC : RUN;
      end else if (mem_busy) begin
        // Freeze the whole pipe, including any divider countdown
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        flush_wb  = 1'b1;
      end else if (state == DIV) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
        if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end else begin
        if (hz) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        if (ex_div_start) begin
          state_nxt = DIV;
          cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic,
// expected outputs from a cycle-count reference model.
module tb_pipe_ctrl;

  localparam int unsigned DIV_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs_regf = '0, id_rt_regf = '0, ex_rd_regf = '0, mem_rd_regf = '0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_is_branch = 0;
  logic       ex_wr = 0, ex_is_load = 0, mem_wr = 0, mem_is_load = 0;
  logic       ex_div_start = 0, imem_busy = 0, dmem_busy = 0, exc_valid = 0;

  logic forward_rs, forward_rt, stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb, div_busy, exc_redirect;

  typedef struct packed {
    logic fwd_rs, fwd_rt, s_if, s_id, s_ex, s_mem;
    logic f_id, f_ex, f_mem, f_wb, busy, redir;
  } outs_t;

  outs_t act;
  assign act = {forward_rs, forward_rt, stall_if, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex, flush_mem, flush_wb, div_busy, exc_redirect};

  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    run_len  = 0;
  int    last_len = 0;

  // Reference model state: remaining divider busy cycles, pending redirect
  int    m_div_left = 0;
  bit    m_exc_pend = 1'b0;

  pipe_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .id_rs_regf(id_rs_regf), .id_rt_regf(id_rt_regf),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
    .ex_rd_regf(ex_rd_regf), .ex_wr(ex_wr), .ex_is_load(ex_is_load),
    .mem_rd_regf(mem_rd_regf), .mem_wr(mem_wr), .mem_is_load(mem_is_load),
    .ex_div_start(ex_div_start), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .exc_valid(exc_valid),
    .forward_rs(forward_rs), .forward_rt(forward_rt),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .div_busy(div_busy), .exc_redirect(exc_redirect)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
  endfunction

  function automatic bit hit(input bit uses, input logic [4:0] idx, input bit wr, input logic [4:0] rd);
    return uses && (idx != 5'd0) && wr && (rd == idx);
  endfunction

  // Expected outputs for the current inputs; advances the model by one cycle
  task automatic model(output outs_t e);
    bit rs_ex, rt_ex, rs_mem, rt_mem, hz;
    e = '0;
    if (rst) begin
      m_div_left = 0;
      m_exc_pend = 1'b0;
      return;
    end
    rs_ex  = hit(id_uses_rs, id_rs_regf, ex_wr,  ex_rd_regf);
    rt_ex  = hit(id_uses_rt, id_rt_regf, ex_wr,  ex_rd_regf);
    rs_mem = hit(id_uses_rs, id_rs_regf, mem_wr, mem_rd_regf);
    rt_mem = hit(id_uses_rt, id_rt_regf, mem_wr, mem_rd_regf);
    e.fwd_rs = rs_mem && !mem_is_load;
    e.fwd_rt = rt_mem && !mem_is_load;
    hz = ((rs_ex || rt_ex) && ex_is_load) || (id_is_branch && (rs_ex || rt_ex))
      || (id_is_branch && (rs_mem || rt_mem) && mem_is_load);
    e.busy = (m_div_left > 0) && !m_exc_pend;
    if (exc_valid || m_exc_pend) begin
      {e.f_id, e.f_ex, e.f_mem, e.f_wb} = 4'hF;
      e.redir    = !imem_busy;
      m_div_left = 0;
      m_exc_pend = imem_busy;
    end else if (imem_busy || dmem_busy) begin
      {e.s_if, e.s_id, e.s_ex, e.s_mem} = 4'hF;
      e.f_wb = 1'b1;
    end else if (m_div_left > 0) begin
      {e.s_if, e.s_id, e.s_ex} = 3'b111;
      e.f_mem = 1'b1;
      m_div_left--;
    end else begin
      if (hz) {e.s_if, e.s_id, e.f_ex} = 3'b111;
      if (ex_div_start) m_div_left = DIV_CYCLES;
    end
  endtask

  // Issue one cycle: record expectation, then let the clock edge happen
  task automatic step();
    outs_t e;
    model(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs_regf = '0; id_rt_regf = '0; ex_rd_regf = '0; mem_rd_regf = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
    ex_wr = 0; ex_is_load = 0; mem_wr = 0; mem_is_load = 0;
    ex_div_start = 0; imem_busy = 0; dmem_busy = 0; exc_valid = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare sampled outputs mid-cycle and measure div_busy windows
  always @(negedge clk) begin
    if (exp_q.size() > 0) check("outputs", 32'(act), 32'(exp_q.pop_front()));
    if (div_busy) run_len++;
    else if (run_len > 0) begin
      last_len = run_len;
      run_len  = 0;
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset holds outputs low even with hazards and exceptions present
    rst = 1; idle();
    exc_valid = 1; ex_div_start = 1; id_uses_rs = 1; id_rs_regf = 5'd3;
    ex_wr = 1; ex_rd_regf = 5'd3; ex_is_load = 1; mem_wr = 1; mem_rd_regf = 5'd3;
    steps(2);
    rst = 0; idle(); step();

    // Load-use, then $0 never matches
    ex_rd_regf = 5'd5; ex_wr = 1; ex_is_load = 1; id_rs_regf = 5'd5; id_uses_rs = 1; step();
    id_rs_regf = 5'd0; ex_rd_regf = 5'd0; step();

    // Branch forwarding from MEM, then from a MEM load (stall)
    idle(); id_is_branch = 1; id_rt_regf = 5'd8; id_uses_rt = 1;
    mem_rd_regf = 5'd8; mem_wr = 1; step();
    mem_is_load = 1; step();

    // Plain divider window
    idle(); ex_div_start = 1; step();
    idle(); steps(34);
    check("div_window", 32'(last_len), 32'(DIV_CYCLES));

    // Window stretched by three dmem_busy cycles
    ex_div_start = 1; step();
    idle(); steps(10);
    dmem_busy = 1; steps(3);
    dmem_busy = 0; steps(25);
    check("div_window_frozen", 32'(last_len), 32'(DIV_CYCLES + 3));

    // Exception in the tenth divider cycle
    ex_div_start = 1; step();
    idle(); steps(9);
    exc_valid = 1; ex_div_start = 1; step();
    idle(); steps(3);
    check("div_window_exc", 32'(last_len), 32'd10);

    // Exception while fetch is busy for four cycles
    exc_valid = 1; imem_busy = 1; step();
    exc_valid = 0; steps(3);
    imem_busy = 0; steps(2);

    // Reset in the middle of a divide, then a fresh full window
    ex_div_start = 1; step();
    idle(); steps(20);
    rst = 1; step();
    rst = 0; steps(2);
    check("div_window_rst", 32'(last_len), 32'd20);
    ex_div_start = 1; step();
    idle(); steps(34);
    check("div_window_after_rst", 32'(last_len), 32'(DIV_CYCLES));

    // Random traffic with small register indices to provoke matches
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_rs_regf   = 5'($urandom_range(0, 3));
      id_rt_regf   = 5'($urandom_range(0, 3));
      ex_rd_regf   = 5'($urandom_range(0, 3));
      mem_rd_regf  = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_is_branch = 1'($urandom);
      ex_wr        = 1'($urandom);
      ex_is_load   = 1'($urandom);
      mem_wr       = 1'($urandom);
      mem_is_load  = 1'($urandom);
      ex_div_start = ($urandom_range(0, 19) == 0);
      imem_busy    = ($urandom_range(0, 9) == 0);
      dmem_busy    = ($urandom_range(0, 9) == 0);
      exc_valid    = ($urandom_range(0, 49) == 0);
      step();
    end

    rst = 0; idle(); steps(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
